julia_iter_engine: RTL and testbench



---
 rtl/julia_iter_engine_pkg.sv | 21 ++
 rtl/julia_iter_engine_if.sv | 23 ++
 rtl/julia_iter_engine_fx_mul_q428.sv | 16 +
 rtl/julia_iter_engine.sv | 97 +++++++++
 tb/tb_julia_iter_engine.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/julia_iter_engine_pkg.sv
// julia_iter_engine_pkg: Q4.28 constants, pixel-byte fields and FSM states shared by the Julia core
package julia_iter_engine_pkg;
  localparam logic [31:0] Q_ONE  = 32'h1000_0000;
  localparam logic [31:0] Q_TWO  = 32'h2000_0000;
  localparam logic [31:0] Q_FOUR = 32'h4000_0000;
  localparam int PX_ESC   = 7;
  localparam int PX_CNT_W = 7;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MUL0,
    S_MUL1,
    S_MUL2,
    S_CALC,
    S_WRITE
  } state_t;
  // -2.0 itself counts as escaped, so both bounds are inclusive
  function automatic logic mag_ge_two(input logic [31:0] x);
    return ($signed(x) >= $signed(Q_TWO)) || ($signed(x) <= -$signed(Q_TWO));
  endfunction
endpackage

// File: rtl/julia_iter_engine_if.sv
// julia_iter_engine_if: readout and writeback FIFO handshakes seen by the Julia core
interface julia_iter_engine_if;
  logic        i_Px_Empty;
  logic [7:0]  i_Px_Q;
  logic        o_Px_Rdreq;
  logic        i_Z_Empty;
  logic [63:0] i_Z_Q;
  logic        o_Z_Rdreq;
  logic        i_Px_Full;
  logic        o_Px_Wrreq;
  logic [7:0]  o_Px_Data;
  logic        i_Z_Full;
  logic        o_Z_Wrreq;
  logic [63:0] o_Z_Data;
  modport master (
    input  i_Px_Empty, i_Px_Q, i_Z_Empty, i_Z_Q, i_Px_Full, i_Z_Full,
    output o_Px_Rdreq, o_Z_Rdreq, o_Px_Wrreq, o_Px_Data, o_Z_Wrreq, o_Z_Data
  );
  modport slave (
    output i_Px_Empty, i_Px_Q, i_Z_Empty, i_Z_Q, i_Px_Full, i_Z_Full,
    input  o_Px_Rdreq, o_Z_Rdreq, o_Px_Wrreq, o_Px_Data, o_Z_Wrreq, o_Z_Data
  );
endinterface

// File: rtl/julia_iter_engine_fx_mul_q428.sv
// fx_mul_q428: registered signed Q4.28 multiplier, one cycle latency, result truncated toward -inf
module fx_mul_q428 #(
  parameter int FRAC_BITS = 28
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  output logic [31:0] o_P
);
  logic signed [63:0] full;
  assign full = 64'(signed'(i_A)) * 64'(signed'(i_B));
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) o_P <= '0;
    else o_P <= 32'(full >>> FRAC_BITS);
endmodule

// File: rtl/julia_iter_engine.sv
// julia_iter_engine: one Julia iteration z' = z^2 + c per pixel between readout and writeback FIFOs
module julia_iter_engine
  import julia_iter_engine_pkg::*;
#(
  parameter int MAX_ITER  = 127,
  parameter int FRAC_BITS = 28
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic [31:0]         i_C_Re,
  input  logic [31:0]         i_C_Im,
  julia_iter_engine_if.master fifo,
  output logic                o_Busy,
  output logic [31:0]         o_Pixels_Done
);
  localparam logic [PX_CNT_W-1:0] MAX_CNT = PX_CNT_W'(MAX_ITER);
  state_t      state;
  logic [7:0]  px;
  logic [31:0] zr, zi, zr2, zi2, mul_a, mul_b, mul_p, nzr, nzi;
  logic [32:0] sq;
  logic        go, fire, skip, bypass, zfire, over;
  // pops are issued straight from IDLE so the non-showahead data lands in FETCH
  assign go = (state == S_IDLE) & ~i_Reset & ~fifo.i_Px_Empty & ~fifo.i_Z_Empty
            & ~fifo.i_Px_Full & ~fifo.i_Z_Full;
  assign fifo.o_Px_Rdreq = go;
  assign fifo.o_Z_Rdreq  = go;
  assign o_Busy = (state != S_IDLE);
  assign fire = mag_ge_two(fifo.i_Z_Q[31:0]) | mag_ge_two(fifo.i_Z_Q[63:32]);
  assign skip = fifo.i_Px_Q[PX_ESC] | (fifo.i_Px_Q[PX_CNT_W-1:0] == MAX_CNT) | fire;
  // MUL0: zr*zr, MUL1: zi*zi, MUL2: zr*zi
  assign mul_a = (state == S_MUL1) ? zi : zr;
  assign mul_b = (state == S_MUL0) ? zr : zi;
  assign sq    = {1'b0, zr2} + {1'b0, zi2};
  assign over  = sq > {1'b0, Q_FOUR};
  assign nzr   = zr2 - zi2 + i_C_Re;
  assign nzi   = {mul_p[30:0], 1'b0} + i_C_Im;
  fx_mul_q428 #(.FRAC_BITS(FRAC_BITS)) u_mul (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .i_A    (mul_a),
    .i_B    (mul_b),
    .o_P    (mul_p)
  );
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      state           <= S_IDLE;
      px              <= '0;
      zr              <= '0;
      zi              <= '0;
      zr2             <= '0;
      zi2             <= '0;
      bypass          <= 1'b0;
      zfire           <= 1'b0;
      fifo.o_Px_Wrreq <= 1'b0;
      fifo.o_Z_Wrreq  <= 1'b0;
      fifo.o_Px_Data  <= '0;
      fifo.o_Z_Data   <= '0;
      o_Pixels_Done   <= '0;
    end else begin
      fifo.o_Px_Wrreq <= 1'b0;
      fifo.o_Z_Wrreq  <= 1'b0;
      case (state)
        S_IDLE:  state <= go ? S_FETCH : S_IDLE;
        S_FETCH: begin
          px     <= fifo.i_Px_Q;
          zr     <= fifo.i_Z_Q[31:0];
          zi     <= fifo.i_Z_Q[63:32];
          zfire  <= fire;
          bypass <= skip;
          state  <= skip ? S_CALC : S_MUL0;
        end
        S_MUL0:  state <= S_MUL1;
        S_MUL1:  begin
          zr2   <= mul_p;
          state <= S_MUL2;
        end
        S_MUL2:  begin
          zi2   <= mul_p;
          state <= S_CALC;
        end
        S_CALC:  begin
          fifo.o_Px_Data  <= bypass ? {px[PX_ESC] | zfire, px[PX_CNT_W-1:0]}
                           : over ? {1'b1, px[PX_CNT_W-1:0]}
                           : {1'b0, px[PX_CNT_W-1:0] + 7'd1};
          fifo.o_Z_Data   <= (bypass | over) ? {zi, zr} : {nzi, nzr};
          fifo.o_Px_Wrreq <= 1'b1;
          fifo.o_Z_Wrreq  <= 1'b1;
          state           <= S_WRITE;
        end
        S_WRITE: begin
          o_Pixels_Done <= o_Pixels_Done + 32'd1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_julia_iter_engine.sv
// tb_julia_iter_engine: scoreboard bench for the Julia iteration core with behavioural FIFOs
module tb_julia_iter_engine;
  import julia_iter_engine_pkg::*;
  typedef struct {
    logic [7:0]  px;
    logic [63:0] z;
    int          lat;
  } exp_t;
  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic [31:0] c_re = '0, c_im = '0, done;
  logic        busy;
  logic [7:0]  pxq[$];
  logic [63:0] zq[$];
  exp_t        expq[$];
  exp_t        m_e;
  int          checks = 0, errors = 0, cyc = 0, pop_cyc = 0, done_exp = 0;

  julia_iter_engine_if ifc ();
  julia_iter_engine dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_C_Re       (c_re),
    .i_C_Im       (c_im),
    .fifo         (ifc),
    .o_Busy       (busy),
    .o_Pixels_Done(done)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge i_Clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] px, input logic [63:0] z, input logic [7:0] epx,
                      input logic [63:0] ez, input int lat);
    exp_t e;
    e.px = epx;
    e.z = ez;
    e.lat = lat;
    pxq.push_back(px);
    zq.push_back(z);
    expq.push_back(e);
    done_exp++;
  endtask

  task automatic drain(input bit rnd);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (rnd) begin
        ifc.i_Px_Full = ($urandom_range(0, 3) == 0);
        ifc.i_Z_Full  = ($urandom_range(0, 3) == 0);
      end
      if (expq.size() == 0 && pxq.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    ifc.i_Px_Full = 1'b0;
    ifc.i_Z_Full  = 1'b0;
    chk("drain_done", 64'(ok), 64'd1);
    step(2);
    chk("pixels_done", 64'(done), 64'(done_exp));
  endtask

  // readout FIFO model: non-showahead, data appears the cycle after rdreq
  always @(posedge i_Clk) begin
    if (ifc.o_Px_Rdreq) begin
      if (pxq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_px_empty");
      end else ifc.i_Px_Q <= pxq.pop_front();
    end
    if (ifc.o_Z_Rdreq) begin
      if (zq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_z_empty");
      end else ifc.i_Z_Q <= zq.pop_front();
    end
    #1;
    ifc.i_Px_Empty = (pxq.size() == 0);
    ifc.i_Z_Empty  = (zq.size() == 0);
  end

  // monitor: pairing, gating, latency and scoreboard compare on every push
  always @(negedge i_Clk) begin
    cyc++;
    if (ifc.o_Px_Rdreq | ifc.o_Z_Rdreq) begin
      chk("rdreq_pair", 64'(ifc.o_Px_Rdreq), 64'(ifc.o_Z_Rdreq));
      chk("rdreq_while_full", 64'(ifc.i_Px_Full | ifc.i_Z_Full), 64'd0);
      pop_cyc = cyc;
    end
    if (ifc.o_Px_Wrreq | ifc.o_Z_Wrreq) begin
      chk("wrreq_pair", 64'(ifc.o_Px_Wrreq), 64'(ifc.o_Z_Wrreq));
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push px=%h z=%h", ifc.o_Px_Data, ifc.o_Z_Data);
      end else begin
        m_e = expq.pop_front();
        chk("px_data", 64'(ifc.o_Px_Data), 64'(m_e.px));
        chk("z_data", ifc.o_Z_Data, m_e.z);
        chk("latency", 64'(cyc - pop_cyc), 64'(m_e.lat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  p;
    logic [63:0] z;
    logic [31:0] d0;
    int          nrd;
    bit          seen;
    ifc.i_Px_Empty = 1'b1;
    ifc.i_Z_Empty  = 1'b1;
    ifc.i_Px_Full  = 1'b0;
    ifc.i_Z_Full   = 1'b0;
    ifc.i_Px_Q     = '0;
    ifc.i_Z_Q      = '0;
    step(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_px_wrreq", 64'(ifc.o_Px_Wrreq), 64'd0);
    chk("rst_z_wrreq", 64'(ifc.o_Z_Wrreq), 64'd0);
    chk("rst_px_data", 64'(ifc.o_Px_Data), 64'd0);
    chk("rst_z_data", ifc.o_Z_Data, 64'd0);
    i_Reset = 1'b0;
    step(2);
    push(8'h00, 64'h0, 8'h01, 64'h0, 6);
    drain(0);
    push(8'h05, {Q_ONE, Q_ONE}, 8'h06, {32'h2000_0000, 32'h0000_0000}, 6);
    drain(0);
    c_re = 32'h0400_0000;
    c_im = 32'hF800_0000;
    push(8'h10, {32'h0800_0000, 32'hF000_0000}, 8'h11, {32'hE800_0000, 32'h1000_0000}, 6);
    drain(0);
    c_re = '0;
    c_im = '0;
    push(8'h20, {32'h1800_0000, 32'h1800_0000}, 8'hA0, {32'h1800_0000, 32'h1800_0000}, 6);
    push(8'h30, {32'h0, 32'h1FFF_FFFF}, 8'h31, {32'h0, 32'h3FFF_FFFC}, 6);
    push(8'h03, {32'h0, Q_TWO}, 8'h83, {32'h0, Q_TWO}, 3);
    push(8'h00, {32'hE000_0000, 32'h0}, 8'h80, {32'hE000_0000, 32'h0}, 3);
    drain(0);
    d0 = done;
    push(8'h7F, {Q_ONE, Q_ONE}, 8'h7F, {Q_ONE, Q_ONE}, 3);
    push(8'h85, {32'h0800_0000, 32'h0800_0000}, 8'h85, {32'h0800_0000, 32'h0800_0000}, 3);
    drain(0);
    chk("done_plus2", 64'(done - d0), 64'd2);
    ifc.i_Z_Full = 1'b1;
    push(8'h40, 64'h0, 8'h41, 64'h0, 6);
    nrd = 0;
    repeat (10) begin
      step();
      nrd += int'(ifc.o_Px_Rdreq | ifc.o_Z_Rdreq);
    end
    chk("no_rdreq_while_zfull", 64'(nrd), 64'd0);
    chk("idle_while_zfull", 64'(busy), 64'd0);
    ifc.i_Z_Full = 1'b0;
    drain(0);
    for (int i = 0; i < 100; i++) begin
      r = $urandom;
      if (r[0]) begin
        p = 8'h80 | {1'b0, r[7:1]};
        z = {$urandom, $urandom};
        push(p, z, p, z, 3);
      end else begin
        p = 8'($urandom_range(0, 126));
        push(p, 64'h0, p + 8'd1, 64'h0, 6);
      end
    end
    drain(1);
    push(8'h50, {32'h0800_0000, 32'h0800_0000}, 8'h51, 64'h0, 6);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.o_Px_Rdreq) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("pop_seen", 64'(seen), 64'd1);
    step(3);
    chk("busy_in_mul1", 64'(busy), 64'd1);
    i_Reset = 1'b1;
    expq.delete();
    pxq.delete();
    zq.delete();
    done_exp = 0;
    step();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_px_wrreq", 64'(ifc.o_Px_Wrreq), 64'd0);
    chk("midrst_rdreq", 64'(ifc.o_Px_Rdreq | ifc.o_Z_Rdreq), 64'd0);
    chk("midrst_z_data", ifc.o_Z_Data, 64'd0);
    step(2);
    i_Reset = 1'b0;
    step(2);
    push(8'h00, 64'h0, 8'h01, 64'h0, 6);
    drain(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
